// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the adc_spi_resp SPI responder.
//   state_e     - responder frame state (IDLE, SHIFT)
//   FRAME_BITS  - SCLK rises in a valid command frame
//   CHNL_MSB/LSB- command bits carrying the channel address
package adc_spi_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [4:0]  FRAME_BITS  = 5'd16;
  localparam logic [4:0]  BIT_CNT_MAX = 5'd17;
  localparam int unsigned CHNL_MSB    = 13;
  localparam int unsigned CHNL_LSB    = 11;
  localparam int unsigned NUM_CHNL    = 8;
  localparam int unsigned VAL_W       = 12;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: two-flop synchronizer for an asynchronous pin, followed by an
// edge register so rise/fall can be flagged for one clk.
//   clk, rst_n - system clock, async active-low reset
//   d_i        - asynchronous pin
//   q_o        - synchronized level
//   rise_o     - one-clk flag: synchronized level went 0->1
//   fall_o     - one-clk flag: synchronized level went 1->0
// RST_VAL is the level all three flops take in reset (the pin's idle level).
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/adc_spi_resp.sv
// adc_spi_resp: SPI responder standing in for an 8-channel 12-bit ADC.
// A 16-bit command frame latches channel bits [13:11]; the following frame
// shifts out {4'h0, val[channel]} MSB first.
//   clk, rst_n          - system clock, async active-low reset
//   SS_n, SCLK, MOSI    - SPI pins from the master (asynchronous to clk)
//   MISO                - SPI data to the master
//   wr_en/wr_chnnl/wr_data - parallel write into the channel value file
//   cur_chnnl           - channel latched by the last valid frame
//   frm_done / frm_err  - one-clk pulse at the end of a good / bad frame
module adc_spi_resp
  import adc_spi_pkg::*;
#(
  parameter logic [11:0] RST_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnnl,
  input  logic [11:0] wr_data,
  output logic [2:0]  cur_chnnl,
  output logic        frm_done,
  output logic        frm_err
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .q_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI),
    .q_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_edges = ^{sclk_sync, mosi_rise, mosi_fall};

  // Channel value file, writable at any time.
  logic [VAL_W-1:0] val_q [NUM_CHNL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHNL; i++) val_q[i] <= RST_VAL;
    end else if (wr_en) begin
      val_q[wr_chnnl] <= wr_data;
    end
  end

  // The SS_n synchronizer resets to "high", so leaving reset with SS_n held
  // low looks like a fall. A frame may only start once SS_n has been seen
  // high after the sync chain has filled, which keeps a reset mid-frame from
  // turning the tail of that frame into a new one.
  logic [1:0] settle_q;
  logic       armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_q | (settle_q[1] & ss_sync);
    end
  end

  state_e      state_q, state_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  cur_q, cur_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        start;

  assign start = ss_fall & armed_q;

  // State register and frame datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    cur_d  = cur_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d  = {4'h0, val_q[cur_q]};
          rx_d  = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (cnt_q == FRAME_BITS) begin
            cur_d  = rx_q[CHNL_MSB:CHNL_LSB];
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d = {rx_q[14:0], mosi_sync};
          if (cnt_q != BIT_CNT_MAX) cnt_d = cnt_q + 5'd1;
        end else if (sclk_fall && (cnt_q != 5'd0)) begin
          // The fall before the first rise only opens the frame; bit 15 is
          // already on MISO from the load.
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign MISO      = tx_q[15];
  assign cur_chnnl = cur_q;
  assign frm_done  = done_q;
  assign frm_err   = err_q;

endmodule

// File: tb/tb_adc_spi_resp.sv
module tb_adc_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_chnnl = '0;
  logic [11:0] wr_data = '0;
  logic [2:0]  cur_chnnl;
  logic        frm_done;
  logic        frm_err;

  int total = 0;
  int bad   = 0;

  // Reference model: channel values and the channel of the last valid frame.
  logic [11:0] vals [8];
  logic [2:0]  cur_m;

  logic [15:0] rx_got;
  int          n_done, n_err, lat;

  always #5 clk = ~clk;

  adc_spi_resp #(.RST_VAL(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .wr_en(wr_en), .wr_chnnl(wr_chnnl), .wr_data(wr_data),
    .cur_chnnl(cur_chnnl), .frm_done(frm_done), .frm_err(frm_err)
  );

  task automatic do_write(input logic [2:0] ch, input logic [11:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_chnnl = ch; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    vals[ch] = v;
  endtask

  // Drop SS_n; optionally write (ch, v) on the clk where the responder
  // sees the fall (third posedge after the pin edge).
  task automatic ss_low(input logic coinc, input logic [2:0] ch, input logic [11:0] v);
    rx_got = '0;
    @(negedge clk);
    SS_n = 1'b0;
    if (coinc) begin
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_chnnl = ch; wr_data = v;
      @(negedge clk);
      wr_en = 1'b0;
      vals[ch] = v;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
  endtask

  // SCLK low then high for each bit; MISO sampled at the rising pin edge.
  task automatic sclk_bits(input logic [15:0] cmd, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      if (i < 16) MOSI = cmd[15-i];
      else        MOSI = 1'b0;
      SCLK = 1'b0;
      repeat (6) @(negedge clk);
      SCLK = 1'b1;
      if (i < 16) rx_got[15-i] = MISO;
      repeat (6) @(negedge clk);
    end
  endtask

  // Raise SS_n and watch a bounded window for the end-of-frame pulses.
  task automatic ss_high();
    SS_n = 1'b1; MOSI = 1'b0;
    n_done = 0; n_err = 0; lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (frm_done) n_done++;
      if (frm_err)  n_err++;
      if (lat < 0 && (frm_done || frm_err)) lat = k;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits);
    ss_low(1'b0, 3'd0, 12'h000);
    sclk_bits(cmd, 0, nbits);
    ss_high();
  endtask

  task automatic test_reset();
    int pulses;
    logic [15:0] cmd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    total++; if (cur_chnnl !== 3'd0) begin bad++; $display("FAIL reset_cur got=%0d exp=0", cur_chnnl); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) vals[i] = 12'h000;
    cur_m = 3'd0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frm_done || frm_err) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL reset_pulses got=%0d exp=0", pulses); end
    for (int ch = 0; ch < 8; ch++) begin
      cmd = 16'($urandom);
      cmd[13:11] = 3'(ch);
      run_frame(cmd, 16);
      total++; if (rx_got !== 16'h0000) begin bad++; $display("FAIL reset_read ch=%0d got=%h exp=0000", ch, rx_got); end
      total++; if (n_done !== 1 || n_err !== 0) begin bad++; $display("FAIL reset_read_pulse done=%0d err=%0d exp 1/0", n_done, n_err); end
      cur_m = 3'(ch);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    do_write(3'd1, 12'hA5C);
    exp = {4'h0, vals[cur_m]};
    run_frame(16'h0800, 16);
    total++; if (rx_got !== exp) begin bad++; $display("FAIL basic_first got=%h exp=%h", rx_got, exp); end
    total++; if (n_done !== 1 || n_err !== 0) begin bad++; $display("FAIL basic_done done=%0d err=%0d exp 1/0", n_done, n_err); end
    total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    total++; if (cur_chnnl !== 3'd1) begin bad++; $display("FAIL basic_cur got=%0d exp=1", cur_chnnl); end
    cur_m = 3'd1;
    run_frame(16'h0800, 16);
    total++; if (rx_got !== 16'h0A5C) begin bad++; $display("FAIL basic_read got=%h exp=0a5c", rx_got); end
  endtask

  task automatic test_round_robin();
    logic [15:0] cmds [6];
    logic [15:0] exp;
    cmds = '{16'h0800, 16'h0000, 16'h2000, 16'h1000, 16'h1800, 16'h3800};
    for (int i = 0; i < 8; i++) do_write(3'(i), 12'(i * 12'h111 + $urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) begin
      exp = {4'h0, vals[cur_m]};
      run_frame(cmds[i], 16);
      cur_m = cmds[i][13:11];
      total++; if (rx_got !== exp) begin bad++; $display("FAIL rr_read i=%0d got=%h exp=%h", i, rx_got, exp); end
      total++; if (cur_chnnl !== cur_m) begin bad++; $display("FAIL rr_cur i=%0d got=%0d exp=%0d", i, cur_chnnl, cur_m); end
    end
    total++; if (cur_chnnl !== 3'd7) begin bad++; $display("FAIL rr_final_cur got=%0d exp=7", cur_chnnl); end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    exp = {4'h0, vals[cur_m]};
    run_frame(16'h2000, 8);
    total++; if (n_err !== 1 || n_done !== 0) begin bad++; $display("FAIL abort8_pulse err=%0d done=%0d exp 1/0", n_err, n_done); end
    total++; if (cur_chnnl !== cur_m) begin bad++; $display("FAIL abort8_cur got=%0d exp=%0d", cur_chnnl, cur_m); end
    total++; if ((rx_got & 16'hFF00) !== (exp & 16'hFF00)) begin bad++; $display("FAIL abort8_bits got=%h exp=%h", rx_got & 16'hFF00, exp & 16'hFF00); end
    run_frame(16'h1000, 17);
    total++; if (n_err !== 1 || n_done !== 0) begin bad++; $display("FAIL abort17_pulse err=%0d done=%0d exp 1/0", n_err, n_done); end
    total++; if (cur_chnnl !== cur_m) begin bad++; $display("FAIL abort17_cur got=%0d exp=%0d", cur_chnnl, cur_m); end
    total++; if (rx_got !== exp) begin bad++; $display("FAIL abort17_read got=%h exp=%h", rx_got, exp); end
    run_frame(16'h1000, 16);
    total++; if (rx_got !== exp) begin bad++; $display("FAIL abort_next_read got=%h exp=%h", rx_got, exp); end
    cur_m = 3'd2;
    total++; if (cur_chnnl !== 3'd2 || n_done !== 1) begin bad++; $display("FAIL abort_next_cur got=%0d done=%0d exp 2/1", cur_chnnl, n_done); end
  endtask

  task automatic test_write_mid();
    run_frame(16'h2800, 16);
    cur_m = 3'd5;
    do_write(3'd5, 12'h123);
    ss_low(1'b0, 3'd0, 12'h000);
    sclk_bits(16'h2800, 0, 7);
    do_write(3'd5, 12'h456);
    sclk_bits(16'h2800, 7, 9);
    ss_high();
    total++; if (rx_got !== 16'h0123) begin bad++; $display("FAIL wmid_inflight got=%h exp=0123", rx_got); end
    run_frame(16'h2800, 16);
    total++; if (rx_got !== 16'h0456) begin bad++; $display("FAIL wmid_next got=%h exp=0456", rx_got); end
    ss_low(1'b1, 3'd5, 12'h789);
    sclk_bits(16'h2800, 0, 16);
    ss_high();
    total++; if (rx_got !== 16'h0456) begin bad++; $display("FAIL wcoinc_old got=%h exp=0456", rx_got); end
    run_frame(16'h2800, 16);
    total++; if (rx_got !== 16'h0789) begin bad++; $display("FAIL wcoinc_new got=%h exp=0789", rx_got); end
  endtask

  task automatic test_random();
    logic [15:0] cmd, exp;
    logic [2:0]  wch;
    logic [11:0] wv;
    int          midbit;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(3'($urandom), 12'($urandom));
      cmd    = 16'($urandom);
      exp    = {4'h0, vals[cur_m]};
      midbit = $urandom_range(1, 15);
      wch    = 3'($urandom);
      wv     = 12'($urandom);
      ss_low(1'b0, 3'd0, 12'h000);
      sclk_bits(cmd, 0, midbit);
      if ($urandom_range(0, 1) == 1) do_write(wch, wv);
      sclk_bits(cmd, midbit, 16 - midbit);
      ss_high();
      cur_m = cmd[13:11];
      total++; if (rx_got !== exp) begin bad++; $display("FAIL rand_read n=%0d got=%h exp=%h", n, rx_got, exp); end
      total++; if (cur_chnnl !== cur_m || n_done !== 1 || n_err !== 0) begin
        bad++; $display("FAIL rand_cur n=%0d got=%0d exp=%0d done=%0d err=%0d", n, cur_chnnl, cur_m, n_done, n_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] v;
    do_write(cur_m, 12'hFFF);
    ss_low(1'b0, 3'd0, 12'h000);
    sclk_bits(16'h3000, 0, 10);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rmid_pre_miso got=%b exp=1", MISO); end
    rst_n = 1'b0;
    #1;
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rmid_miso got=%b exp=0", MISO); end
    total++; if (cur_chnnl !== 3'd0) begin bad++; $display("FAIL rmid_cur got=%0d exp=0", cur_chnnl); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) vals[i] = 12'h000;
    cur_m = 3'd0;
    sclk_bits(16'h3000, 10, 6);
    ss_high();
    total++; if (n_done !== 0 || n_err !== 0) begin bad++; $display("FAIL rmid_no_pulse done=%0d err=%0d exp 0/0", n_done, n_err); end
    run_frame(16'h1000, 16);
    total++; if (rx_got !== 16'h0000 || n_done !== 1 || cur_chnnl !== 3'd2) begin
      bad++; $display("FAIL rmid_after got=%h done=%0d cur=%0d exp 0000/1/2", rx_got, n_done, cur_chnnl);
    end
    cur_m = 3'd2;
    v = 12'($urandom);
    do_write(3'd2, v);
    run_frame(16'h1000, 16);
    total++; if (rx_got !== {4'h0, v}) begin bad++; $display("FAIL rmid_read got=%h exp=%h", rx_got, {4'h0, v}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_write_mid();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_resp.md
# adc_spi_resp

SPI responder modelling the 8-channel 12-bit A/D converter at the far end of the slide-pot A/D interface. It receives 16-bit command frames from the SPI master, latches the addressed channel, and returns that channel's 12-bit value on the following frame. Per-channel values are loaded through a parallel write port. It serves as the synthesizable ADC stand-in for system benches and FPGA loopback, sitting directly on the SS_n/SCLK/MOSI/MISO pins.

## Interface
- RST_VAL, 12'h000, reset value of all eight channel value registers
- clk  input  1  system clock; all logic on posedge clk
- rst_n  input  1  asynchronous, active-low reset
- SS_n  input  1  SPI select, active low, asynchronous to clk
- SCLK  input  1  SPI clock, idles high, asynchronous to clk
- MOSI  input  1  SPI data from master, MSB first
- MISO  output  1  SPI data to master, MSB first
- wr_en  input  1  write strobe for channel value register
- wr_chnnl  input  3  channel written when wr_en=1
- wr_data  input  12  value written
- cur_chnnl  output  3  channel latched by last complete frame
- frm_done  output  1  one-clk pulse: valid 16-bit frame ended
- frm_err  output  1  one-clk pulse: frame ended with bit count != 16

## Operation
- SS_n, SCLK, MOSI each pass two sync flops; SS_n fall/rise and SCLK rise/fall detected on synced versions.
- Value file: 8 x 12-bit registers, reset to RST_VAL; written on wr_en regardless of SPI activity.
- States: IDLE, SHIFT.
- IDLE: on SS_n fall -> load tx_shft = {4'h0, val[cur_chnnl]}, rx_shft = 0, bit_cnt = 0, go SHIFT.
- SHIFT, SCLK rise: rx_shft = {rx_shft[14:0], MOSI}; bit_cnt increments, saturates at 17.
- SHIFT, SCLK fall: shift tx_shft left (fill 0) only if bit_cnt != 0 (front-porch fall ignored).
- SHIFT, SS_n rise: if bit_cnt==16, cur_chnnl = rx_shft[13:11], pulse frm_done; else pulse frm_err, cur_chnnl unchanged. Return to IDLE.
- MISO = tx_shft[15] at all times; tx_shft holds its last value in IDLE.
- Response pipelining: each frame returns the channel addressed by the previous valid frame; command bits other than [13:11] are ignored.
- Write to val[cur_chnnl] on the same clk as the SS_n fall detection: tx_shft loads the old value.
- Write during SHIFT does not affect the frame in flight.

## Timing
- Reset: state IDLE, MISO 0, tx_shft 0, rx_shft 0, bit_cnt 0, cur_chnnl 0, frm_done 0, frm_err 0, value file RST_VAL.
- Pin-to-detect latency: 3 clk (2 sync + edge register).
- MISO changes 3 clk after SCLK fall (or SS_n fall for bit 15); the master samples on the next SCLK rise.
- SCLK high and low phases, and SS_n fall to first SCLK edge, each ≥ 4 clk; SS_n high ≥ 4 clk between frames.
- frm_done/frm_err assert 3 clk after the SS_n rise pin edge, for exactly one clk; cur_chnnl updates on the same edge.
- Reset mid-frame: immediate return to IDLE; a later SS_n rise produces no pulse; the next SS_n fall starts a fresh frame.

## Structure
- Package adc_spi_pkg: state enum (IDLE, SHIFT), FRAME_BITS = 16, CHNL_MSB = 13, CHNL_LSB = 11.
- Sub-module spi_edge_sync: 2-flop synchronizer plus rise/fall detect. Three instances (SS_n with reset value 1, SCLK with reset value 1, MOSI with reset value 0).

## Test plan
- Reset: assert rst_n=0 -> MISO=0, cur_chnnl=0, no frm_done/frm_err pulses, all reads return 16'h0000.
- Write val[1]=12'hA5C; frame MOSI=16'h0800 -> frm_done, cur_chnnl=1; next frame (16'h0800) -> MISO shifts 16'h0A5C.
- Round-robin sequence ch1,0,4,2,3,7 (16'h0800,0000,2000,1000,1800,3800), distinct values per channel -> each frame returns the prior frame's channel value; cur_chnnl ends at 7.
- Abort after 8 SCLK rises -> frm_err pulse, cur_chnnl unchanged, next frame returns the old channel's value. 17 rises -> frm_err.
- Write val[cur_chnnl] from 12'h123 to 12'h456 mid-frame -> current frame returns 16'h0123, next frame returns 16'h0456; write coincident with SS_n fall detection -> old value.
- Assert rst_n mid-frame after 10 bits -> MISO=0, cur_chnnl=0, no pulse at SS_n rise, following full frame behaves normally.
